rbm_stochastic_neuron: RTL and testbench

- One stochastic RBM hidden/visible unit: a chain of saturating signed adders accumulates a bias plus the weights whose input bits are set.
- A piecewise-linear sigmoid turns the sum into an 8-bit firing probability.
- An 8-bit LFSR supplies a uniform random number; the registered output bit is 1 when probability > random.
- Replicated per adder group inside an RBM layer.

---
 rtl/rbm_stochastic_neuron.sv | 67 ++++++
 tb/tb_rbm_stochastic_neuron.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rbm_stochastic_neuron.sv
// rbm_stochastic_neuron: stochastic RBM unit; saturating weighted sum, PWL sigmoid, LFSR-sampled output bit.
// The "rand" port is named rand_num because rand is a reserved SystemVerilog keyword.
module rbm_stochastic_neuron #(
    parameter int BITLENGTH = 12,
    parameter int SIG_BITS = 8,
    parameter int INPUT_DIM = 15,
    parameter logic [BITLENGTH-1:0] INF = 12'h7FF,
    parameter logic [SIG_BITS-1:0] SEED = 8'd124
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           data_valid,
    input  logic [INPUT_DIM-1:0]           input_bits,
    input  logic [INPUT_DIM*BITLENGTH-1:0] weights,
    input  logic [BITLENGTH-1:0]           bias,
    output logic [BITLENGTH-1:0]           sum,
    output logic [SIG_BITS-1:0]            prob,
    output logic [SIG_BITS-1:0]            rand_num,
    output logic                           neuron_out,
    output logic                           out_valid
);
    localparam logic [SIG_BITS-1:0] SEED_NZ = (SEED == '0) ? SIG_BITS'(1) : SEED;
    localparam logic [BITLENGTH-1:0] T0 = BITLENGTH'(256);
    localparam logic [BITLENGTH-1:0] T1 = BITLENGTH'(608);
    localparam logic [BITLENGTH-1:0] T2 = BITLENGTH'(1280);

    function automatic logic [BITLENGTH-1:0] sat(input logic [BITLENGTH-1:0] a, input logic [BITLENGTH-1:0] b);
        logic signed [BITLENGTH:0] s;
        s = $signed({a[BITLENGTH-1], a}) + $signed({b[BITLENGTH-1], b});
        return (s > $signed({1'b0, INF})) ? INF :
               (s < $signed({~INF[BITLENGTH-1], ~INF})) ? ~INF : s[BITLENGTH-1:0];
    endfunction

    logic [BITLENGTH-1:0] mag;
    logic [8:0]           y;
    logic [SIG_BITS-1:0]  lfsr;

    // Saturation is applied after every stage, so ordering matters.
    always_comb begin
        sum = bias;
        for (int h = 0; h < INPUT_DIM; h++)
            sum = sat(sum, input_bits[h] ? weights[h*BITLENGTH +: BITLENGTH] : '0);
    end

    always_comb begin
        mag = sum[BITLENGTH-1] ? -sum : sum;
        y = (mag < T0) ? 9'(mag >> 2) + 9'd128 :
            (mag < T1) ? 9'(mag >> 3) + 9'd160 :
            (mag < T2) ? 9'(mag >> 5) + 9'd216 : 9'd256;
        prob = sum[BITLENGTH-1] ? SIG_BITS'(9'd256 - y) : (y[8] ? '1 : SIG_BITS'(y));
    end

    assign rand_num = lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr       <= SEED_NZ;
            neuron_out <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            out_valid <= data_valid;
            if (data_valid)
                neuron_out <= prob > lfsr;
        end
    end
endmodule

// File: tb/tb_rbm_stochastic_neuron.sv
// tb_rbm_stochastic_neuron: directed plus randomized checks against an integer reference model.
module tb_rbm_stochastic_neuron;
    localparam int B = 12;
    localparam int N = 15;

    logic           clock = 0;
    logic           reset;
    logic           data_valid;
    logic [N-1:0]   input_bits;
    logic [N*B-1:0] weights;
    logic [B-1:0]   bias;
    logic [B-1:0]   sum, sum0;
    logic [7:0]     prob, prob0, rand_num, rand0;
    logic           neuron_out, out_valid, out0, ov0;

    int total = 0;
    int bad = 0;
    int m_r = 124;
    int m_out = 0;
    int m_ov = 0;

    rbm_stochastic_neuron dut (
        .clock(clock), .reset(reset), .data_valid(data_valid), .input_bits(input_bits),
        .weights(weights), .bias(bias), .sum(sum), .prob(prob), .rand_num(rand_num),
        .neuron_out(neuron_out), .out_valid(out_valid)
    );

    rbm_stochastic_neuron #(.SEED(8'd0)) dut0 (
        .clock(clock), .reset(reset), .data_valid(data_valid), .input_bits(input_bits),
        .weights(weights), .bias(bias), .sum(sum0), .prob(prob0), .rand_num(rand0),
        .neuron_out(out0), .out_valid(ov0)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int msum();
        int acc = int'($signed(bias));
        for (int h = 0; h < N; h++) begin
            if (input_bits[h]) acc += int'($signed(weights[h*B +: B]));
            acc = (acc > 2047) ? 2047 : (acc < -2048) ? -2048 : acc;
        end
        return acc;
    endfunction

    function automatic int mprob(input int x);
        int a = (x < 0) ? -x : x;
        int y = (a < 256) ? a / 4 + 128 : (a < 608) ? a / 8 + 160 : (a < 1280) ? a / 32 + 216 : 256;
        return (x >= 0) ? ((y > 255) ? 255 : y) : 256 - y;
    endfunction

    function automatic int lfsr_step(input int r);
        int fb = ((r >> 7) ^ (r >> 5) ^ (r >> 4) ^ (r >> 3)) & 1;
        return ((r << 1) | fb) & 255;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_r = 124;
            m_out = 0;
            m_ov = 0;
        end else begin
            if (data_valid) m_out = (mprob(msum()) > m_r) ? 1 : 0;
            m_ov = data_valid ? 1 : 0;
            m_r = lfsr_step(m_r);
        end
    end

    task automatic check_all(input string tag);
        check({tag, "_sum"}, int'($signed(sum)), msum());
        check({tag, "_prob"}, int'(prob), mprob(msum()));
        check({tag, "_rand"}, int'(rand_num), m_r);
        check({tag, "_out"}, int'(neuron_out), m_out);
        check({tag, "_ov"}, int'(out_valid), m_ov);
    endtask

    int pts[7] = '{0, 256, -256, 607, 608, 2047, -2048};
    int pex[7] = '{128, 192, 64, 235, 235, 255, 0};

    initial begin
        reset = 0;
        data_valid = 0;
        input_bits = '0;
        weights = '0;
        bias = '0;
        #1 reset = 1;
        #2;
        check("rst_rand", int'(rand_num), 8'h7C);
        check("rst_rand_seed0", int'(rand0), 1);
        check("rst_out", int'(neuron_out), 0);
        check("rst_ov", int'(out_valid), 0);
        @(negedge clock) reset = 0;
        check("lfsr0", int'(rand_num), 8'h7C);
        @(negedge clock) check("lfsr1", int'(rand_num), 8'hF9);
        @(negedge clock) check("lfsr2", int'(rand_num), 8'hF2);
        check("lfsr_ov", int'(out_valid), 0);
        check("seed0_step", int'(rand0), lfsr_step(lfsr_step(1)));
        repeat (253) @(negedge clock);
        check("lfsr_period", int'(rand_num), 8'h7C);
        check("lfsr_period_ov", int'(out_valid), 0);

        bias = 12'h7F0;
        weights[0 +: B] = 12'h020;
        weights[B +: B] = 12'hFF0;
        input_bits = 15'b11;
        #1 check("sat_chain_hi", int'(sum), 12'h7EF);
        bias = 12'h800;
        weights[0 +: B] = 12'hFFF;
        input_bits = 15'b1;
        #1 check("sat_chain_lo", int'(sum), 12'h800);
        input_bits = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock) bias = 12'(pts[i]);
            #1 check($sformatf("sig_%0d", pts[i]), int'(prob), pex[i]);
        end

        @(negedge clock) begin bias = 12'h7FF; data_valid = 1; end
        @(negedge clock) begin data_valid = 0; check_all("pre_rst"); end
        #1 reset = 1;
        #1;
        check("midrst_rand", int'(rand_num), 8'h7C);
        check("midrst_out", int'(neuron_out), 0);
        check("midrst_ov", int'(out_valid), 0);
        check("midrst_rand_seed0", int'(rand0), 1);
        reset = 0;
        bias = '0;
        data_valid = 1;
        @(negedge clock);
        check("samp_out", int'(neuron_out), 1);
        check("samp_ov", int'(out_valid), 1);
        check("samp_rand", int'(rand_num), 8'hF9);
        data_valid = 0;
        @(negedge clock);
        check("hold_out", int'(neuron_out), 1);
        check("hold_ov", int'(out_valid), 0);
        check("hold_rand", int'(rand_num), 8'hF2);
        data_valid = 1;
        @(negedge clock);
        check("samp2_out", int'(neuron_out), 0);
        check("samp2_ov", int'(out_valid), 1);

        for (int c = 0; c < 400; c++) begin
            check_all("rnd");
            data_valid = ($urandom_range(0, 3) != 0);
            input_bits = N'($urandom);
            bias = ($urandom_range(0, 1) != 0) ? B'($urandom) : B'($urandom_range(0, 511) - 256);
            for (int h = 0; h < N; h++)
                weights[h*B +: B] = ($urandom_range(0, 3) == 0) ? B'($urandom) : B'($urandom_range(0, 255) - 128);
            @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
